smg_bin2bcd_module: RTL and testbench

Sequential binary-to-BCD converter that produces the 12-bit, three-digit BCD word consumed by the seven-segment scan controller as `Number_Sig`. It accepts a 10-bit binary value on a start pulse, runs a shift-and-add-3 (double-dabble) conversion over ten clock cycles, and presents the result on a held output register with a one-cycle done pulse. It sits between the application logic (counters, measured values) and the display scan path.

---
 rtl/smg_bin2bcd_module.sv | 119 +++++++++++
 tb/tb_smg_bin2bcd_module.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/smg_bin2bcd_module.sv
// smg_bin2bcd_module
// Sequential double-dabble converter: a 10-bit binary value in, a
// three-digit BCD word out for the seven-segment scan path. One iteration
// per clock, ten iterations per conversion. The result is held on
// registered outputs, and Done_Sig pulses for one cycle when it loads.
// With CLAMP=1, values above 999 saturate to 999. With CLAMP=0 they show
// their low three decimal digits. Either way Over_Sig is raised.
module smg_bin2bcd_module #(
  parameter bit CLAMP = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start_Sig,
  input  logic [9:0]  Binary_Data,
  output logic        Busy_Sig,
  output logic        Done_Sig,
  output logic        Over_Sig,
  output logic [11:0] Number_Sig
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]  LAST_ITER = 4'd9;
  localparam logic [9:0]  MAX_IN    = 10'd999;
  localparam logic [11:0] SAT_BCD   = 12'h999;

  state_t      state;
  logic [9:0]  bin_q;      // binary operand, shifted out MSB first
  logic [11:0] bcd_q;      // BCD scratch, never visible on the outputs
  logic [3:0]  cnt_q;      // iteration index 0..9
  logic        over_q;     // pending over-range flag for this conversion

  logic [11:0] bcd_adj;    // scratch after the add-3 correction
  logic [11:0] bcd_shift;  // scratch after the one-bit left shift
  logic        bcd_carry;  // bit shifted out of the hundreds digit

  // Add 3 to a digit of 5..9 so that the following doubling carries into
  // the next decade. Digits 0..4 pass through unchanged.
  function automatic logic [3:0] add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

  // One double-dabble step: correct every digit, then shift in the next
  // binary bit.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred.
    bcd_adj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_carry = bcd_adj[11];
    bcd_shift = {bcd_adj[10:0], bin_q[9]};
  end

  // Control FSM, datapath registers and registered outputs share one
  // clocked block.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: the reset clears every register, the scratch and the operand
    // included, so an interrupted conversion leaves nothing behind.
    if (RST) begin
      state      <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      over_q     <= 1'b0;
      Busy_Sig   <= 1'b0;
      Done_Sig   <= 1'b0;
      Over_Sig   <= 1'b0;
      Number_Sig <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout. Every register here sees
      // the values from before the edge, whatever the statement order.
      case (state)
        IDLE: begin
          Done_Sig <= 1'b0;
          if (Start_Sig) begin
            bin_q    <= Binary_Data;
            bcd_q    <= '0;
            cnt_q    <= '0;
            over_q   <= (Binary_Data > MAX_IN);
            Busy_Sig <= 1'b1;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          bcd_q <= bcd_shift;
          bin_q <= {bin_q[8:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          // A carry out of the hundreds digit can only come from a value
          // above 999. Folding it in keeps the flag tied to the datapath.
          over_q <= over_q | bcd_carry;
          if (cnt_q == LAST_ITER) begin
            state      <= DONE;
            Done_Sig   <= 1'b1;
            Over_Sig   <= over_q | bcd_carry;
            Number_Sig <= (CLAMP && (over_q || bcd_carry)) ? SAT_BCD
                                                           : bcd_shift;
          end
        end

        DONE: begin
          Done_Sig <= 1'b0;
          Busy_Sig <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          Done_Sig <= 1'b0;
          Busy_Sig <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smg_bin2bcd_module.sv
// tb_smg_bin2bcd_module
// Drives a CLAMP=1 and a CLAMP=0 instance from the same inputs. A
// transaction-level model predicts the outputs from decimal arithmetic and
// edge counts, and a compare process checks both instances on every falling
// edge. Directed scenarios add hand-computed literal expectations.
module tb_smg_bin2bcd_module;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start_Sig = 1'b0;
  logic [9:0]  Binary_Data = '0;

  logic        busy1, done1, over1;
  logic [11:0] num1;
  logic        busy0, done0, over0;
  logic [11:0] num0;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  run_cmp = 1'b0;

  always #5 CLK = ~CLK;

  smg_bin2bcd_module #(.CLAMP(1'b1)) dut_clamp (
    .CLK(CLK), .RST(RST), .Start_Sig(Start_Sig), .Binary_Data(Binary_Data),
    .Busy_Sig(busy1), .Done_Sig(done1), .Over_Sig(over1), .Number_Sig(num1)
  );

  smg_bin2bcd_module #(.CLAMP(1'b0)) dut_wrap (
    .CLK(CLK), .RST(RST), .Start_Sig(Start_Sig), .Binary_Data(Binary_Data),
    .Busy_Sig(busy0), .Done_Sig(done0), .Over_Sig(over0), .Number_Sig(num0)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Low three decimal digits of v, packed as BCD.
  function automatic logic [11:0] to_bcd(input int v);
    int r;
    r = v % 1000;
    return 12'(((r / 100) << 8) | (((r / 10) % 10) << 4) | (r % 10));
  endfunction

  // ---------------- reference model (transaction level) ----------------
  int          k = 0;
  int          acc_k = 0;
  int          acc_v = 0;
  bit          pend = 1'b0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_over = 1'b0;
  logic [11:0] m_num1 = '0, m_num0 = '0;

  // Predict the outputs after each edge: a start accepted at edge A yields
  // busy over A..A+10, done and new outputs at A+10, and the next accept
  // no earlier than A+12.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_over = 1'b0;
      m_num1 = '0;   m_num0 = '0;
    end else begin
      k++;
      if (pend && k == acc_k + 10) begin
        m_over = (acc_v > 999);
        m_num0 = to_bcd(acc_v);
        m_num1 = (acc_v > 999) ? 12'h999 : to_bcd(acc_v);
      end
      if (pend && k >= acc_k + 12) pend = 1'b0;
      if (!pend && Start_Sig) begin
        pend  = 1'b1;
        acc_k = k;
        acc_v = int'(Binary_Data);
      end
      m_busy = pend && (k <= acc_k + 10);
      m_done = pend && (k == acc_k + 10);
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge CLK) begin
    if (run_cmp) begin
      check("busy_c1", 32'(busy1), 32'(m_busy));
      check("busy_c0", 32'(busy0), 32'(m_busy));
      check("done_c1", 32'(done1), 32'(m_done));
      check("done_c0", 32'(done0), 32'(m_done));
      check("over_c1", 32'(over1), 32'(m_over));
      check("over_c0", 32'(over0), 32'(m_over));
      check("num_c1",  32'(num1),  32'(m_num1));
      check("num_c0",  32'(num0),  32'(m_num0));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_conv(input logic [9:0] v, input logic [11:0] lit1,
                          input logic [11:0] lit0, input logic lit_over);
    int lat;
    @(negedge CLK);
    Start_Sig   = 1'b1;
    Binary_Data = v;
    @(negedge CLK);
    Start_Sig   = 1'b0;
    lat = 0;
    while (!done1 && lat < 20) begin
      Binary_Data = 10'($urandom);
      @(negedge CLK);
      lat++;
    end
    check("latency", 32'(lat), 32'd10);
    if (done1) begin
      check("lit_num_c1", 32'(num1), 32'(lit1));
      check("lit_num_c0", 32'(num0), 32'(lit0));
      check("lit_over",   32'(over1), 32'(lit_over));
      @(negedge CLK);
      check("done_width", 32'(done1), 32'd0);
      check("busy_clear", 32'(busy1), 32'd0);
    end
  endtask

  // Count Done pulses over n falling edges and remember the last result.
  task automatic count_done(input int n, output int dones,
                            output logic [11:0] last);
    dones = 0;
    last  = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (done1) begin
        dones++;
        last = num1;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          dones;
    int          d1_at, d2_at, t;
    logic [11:0] last, d1_num, d2_num;

    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_over", 32'(over1), 32'd0);
    check("rst_num",  32'(num1),  32'h000);
    #2 RST = 1'b0;
    run_cmp = 1'b1;

    // Reset values, then the first conversion.
    run_conv(10'd123, 12'h123, 12'h123, 1'b0);

    // In-range corners.
    run_conv(10'd0,   12'h000, 12'h000, 1'b0);
    run_conv(10'd9,   12'h009, 12'h009, 1'b0);
    run_conv(10'd10,  12'h010, 12'h010, 1'b0);
    run_conv(10'd99,  12'h099, 12'h099, 1'b0);
    run_conv(10'd100, 12'h100, 12'h100, 1'b0);
    run_conv(10'd999, 12'h999, 12'h999, 1'b0);

    // Over-range: saturate vs. low three digits.
    run_conv(10'd1023, 12'h999, 12'h023, 1'b1);
    run_conv(10'd1010, 12'h999, 12'h010, 1'b1);
    run_conv(10'd1000, 12'h999, 12'h000, 1'b1);

    // A start while busy is ignored, and so is a data change after capture.
    @(negedge CLK);
    Start_Sig = 1'b1; Binary_Data = 10'd456;
    @(negedge CLK);
    Start_Sig = 1'b0; Binary_Data = 10'd0;
    repeat (4) @(negedge CLK);
    Start_Sig = 1'b1; Binary_Data = 10'd789;
    @(negedge CLK);
    Start_Sig = 1'b0; Binary_Data = 10'd333;
    count_done(20, dones, last);
    check("busy_ignore_dones", 32'(dones), 32'd1);
    check("busy_ignore_num",   32'(last),  32'h456);

    // Reset mid-conversion.
    @(negedge CLK);
    Start_Sig = 1'b1; Binary_Data = 10'd321;
    @(negedge CLK);
    Start_Sig = 1'b0;
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_num",  32'(num1),  32'h000);
    check("midrst_done", 32'(done1), 32'd0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    count_done(15, dones, last);
    check("midrst_no_done", 32'(dones), 32'd0);
    run_conv(10'd321, 12'h321, 12'h321, 1'b0);

    // Back-to-back with Start_Sig held high.
    @(negedge CLK);
    Start_Sig = 1'b1; Binary_Data = 10'd42;
    @(negedge CLK);
    Binary_Data = 10'd57;
    d1_at = -1; d2_at = -1; d1_num = '0; d2_num = '0;
    for (t = 1; t <= 40 && d2_at < 0; t++) begin
      @(negedge CLK);
      if (done1) begin
        if (d1_at < 0) begin d1_at = t; d1_num = num1; end
        else begin d2_at = t; d2_num = num1; end
      end
    end
    Start_Sig = 1'b0;
    check("b2b_first_at",  32'(d1_at),  32'd10);
    check("b2b_gap",       32'(d2_at - d1_at), 32'd12);
    check("b2b_first_num", 32'(d1_num), 32'h042);
    check("b2b_second_num",32'(d2_num), 32'h057);
    count_done(14, dones, last);
    check("b2b_stop", 32'(dones), 32'd0);

    // Randomized traffic, checked each cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      Start_Sig = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0)
        Binary_Data = 10'(1000 + $urandom_range(0, 23));
      else
        Binary_Data = 10'($urandom);
      if (i == 300) begin
        #2 RST = 1'b1;
        @(negedge CLK);
        #2 RST = 1'b0;
      end
    end
    @(negedge CLK);
    Start_Sig = 1'b0;
    repeat (14) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
